// File: rtl/amm_arb_pkg.sv
// Shared types and constants for the Avalon-MM round-robin arbiter.
package amm_arb_pkg;

  localparam int AMM_AW  = 32;
  localparam int AMM_DW  = 32;
  localparam int AMM_BEW = 4;

  localparam logic [AMM_DW-1:0] AMM_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic {IDLE, BUSY} arb_state_t;

endpackage

// File: rtl/amm_rr_pick.sv
// Combinational round-robin picker: first requesting index after 'last', scanning cyclically.
module amm_rr_pick
  import amm_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int LW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  win,
  output logic          valid
);

  logic found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req[k] && (k == (int'(last) + i) % N)) begin
          win[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/amm_arbiter.sv
// N-to-1 Avalon-MM arbiter, round-robin, grant held until the downstream handshake completes.
//   state | meaning
//   IDLE  | no owner; arbitrate among live requests this cycle
//   BUSY  | grant registered; requester W drives the downstream port
module amm_arbiter
  import amm_arb_pkg::*;
#(
  parameter int                N          = 2,
  parameter int                P_TIMEOUT  = 0,
  parameter logic [AMM_DW-1:0] P_ERR_DATA = AMM_ERR_DATA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N*AMM_AW-1:0]   s_address,
  input  logic [N*AMM_DW-1:0]   s_writedata,
  input  logic [N*AMM_BEW-1:0]  s_byteenable,
  input  logic [N-1:0]          s_read,
  input  logic [N-1:0]          s_write,
  output logic [N-1:0]          s_waitrequest,
  output logic [AMM_DW-1:0]     s_readdata,
  output logic [AMM_AW-1:0]     m_address,
  output logic [AMM_DW-1:0]     m_writedata,
  output logic [AMM_BEW-1:0]    m_byteenable,
  output logic                  m_read,
  output logic                  m_write,
  input  logic                  m_waitrequest,
  input  logic [AMM_DW-1:0]     m_readdata,
  output logic [N-1:0]          grant,
  output logic                  timeout,
  output logic [2:0]            timeout_id,
  input  logic                  timeout_clr
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;

  arb_state_t    state;
  logic [LW-1:0] last;
  logic [LW-1:0] gnt_idx;
  logic [LW-1:0] pick_idx;
  logic [N-1:0]  req;
  logic [N-1:0]  pick_win;
  logic          pick_valid;
  logic          sel_read;
  logic          sel_write;
  logic          active;
  logic          wd_fire;
  logic [CW-1:0] wait_cnt;

  assign req = s_read | s_write;

  amm_rr_pick #(.N(N), .LW(LW)) u_pick (
    .req   (req),
    .last  (last),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (pick_win[k]) pick_idx = LW'(k);
    end
  end

  // Grant is zero in IDLE, so the mux naturally parks the downstream port with strobes low.
  always_comb begin
    m_address    = '0;
    m_writedata  = '0;
    m_byteenable = '0;
    sel_read     = 1'b0;
    sel_write    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) begin
        m_address    = s_address[k*AMM_AW +: AMM_AW];
        m_writedata  = s_writedata[k*AMM_DW +: AMM_DW];
        m_byteenable = s_byteenable[k*AMM_BEW +: AMM_BEW];
        sel_read     = s_read[k];
        sel_write    = s_write[k];
      end
    end
  end

  // Read wins when a requester raises both strobes.
  assign m_read  = sel_read;
  assign m_write = sel_write & ~sel_read;
  assign active  = sel_read | sel_write;

  assign wd_fire = (P_TIMEOUT > 0) && (state == BUSY) && active && m_waitrequest
                   && (wait_cnt == CW'(P_TIMEOUT));

  assign s_waitrequest = ~grant | {N{m_waitrequest & ~wd_fire}};
  assign s_readdata    = wd_fire ? P_ERR_DATA : m_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      gnt_idx    <= '0;
      last       <= LW'(N - 1);
      wait_cnt   <= '0;
      timeout    <= 1'b0;
      timeout_id <= '0;
    end else begin
      if (wd_fire) begin
        timeout    <= 1'b1;
        timeout_id <= 3'(gnt_idx);
      end else if (timeout_clr) begin
        timeout <= 1'b0;
      end

      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (pick_valid) begin
            grant   <= pick_win;
            gnt_idx <= pick_idx;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!active) begin
            grant <= '0;
            state <= IDLE;
          end else if (!m_waitrequest || wd_fire) begin
            grant <= '0;
            last  <= gnt_idx;
            state <= IDLE;
          end else if (P_TIMEOUT > 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amm_arbiter.sv
// Self-checking bench for amm_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_amm_arbiter;

  localparam int          N    = 3;
  localparam int          P_TO = 6;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*32-1:0] s_address;
  logic [N*32-1:0] s_writedata;
  logic [N*4-1:0]  s_byteenable;
  logic [N-1:0]    s_read;
  logic [N-1:0]    s_write;
  logic [N-1:0]    s_waitrequest;
  logic [31:0]     s_readdata;
  logic [31:0]     m_address;
  logic [31:0]     m_writedata;
  logic [3:0]      m_byteenable;
  logic            m_read;
  logic            m_write;
  logic            m_waitrequest;
  logic [31:0]     m_readdata;
  logic [N-1:0]    grant;
  logic            timeout;
  logic [2:0]      timeout_id;
  logic            timeout_clr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  amm_arbiter #(.N(N), .P_TIMEOUT(P_TO), .P_ERR_DATA(ERR)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_address     (s_address),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_waitrequest (s_waitrequest),
    .s_readdata    (s_readdata),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .grant         (grant),
    .timeout       (timeout),
    .timeout_id    (timeout_id),
    .timeout_clr   (timeout_clr)
  );

  // Reference model: owner as an integer index, plain arithmetic for the cyclic scan.
  bit   mb_busy;
  int   mb_owner;
  int   mb_last;
  int   mb_wait;
  bit   mb_to;
  int   mb_toid;

  logic [N-1:0] e_grant, e_swait;
  logic         e_mread, e_mwrite;
  logic [31:0]  e_addr, e_wdata, e_rdata;
  logic [3:0]   e_be;
  bit           e_force;

  function automatic void model_init();
    mb_busy = 0; mb_owner = 0; mb_last = N - 1; mb_wait = 0; mb_to = 0; mb_toid = 0;
  endfunction

  function automatic void model_expect();
    e_grant = '0; e_swait = '1; e_mread = 1'b0; e_mwrite = 1'b0;
    e_addr = '0; e_wdata = '0; e_be = '0; e_force = 0;
    if (mb_busy) begin
      e_grant[mb_owner] = 1'b1;
      e_mread  = s_read[mb_owner];
      e_mwrite = s_write[mb_owner] && !s_read[mb_owner];
      e_addr   = s_address[mb_owner*32 +: 32];
      e_wdata  = s_writedata[mb_owner*32 +: 32];
      e_be     = s_byteenable[mb_owner*4 +: 4];
      e_force  = (e_mread || e_mwrite) && m_waitrequest && (mb_wait == P_TO);
      e_swait[mb_owner] = m_waitrequest && !e_force;
    end
    e_rdata = e_force ? ERR : m_readdata;
  endfunction

  function automatic void model_advance();
    int k;
    if (reset) begin
      model_init();
      return;
    end
    if (e_force) begin
      mb_to = 1; mb_toid = mb_owner;
    end else if (timeout_clr) begin
      mb_to = 0;
    end
    if (!mb_busy) begin
      for (int d = 1; d <= N; d++) begin
        k = (mb_last + d) % N;
        if (s_read[k] || s_write[k]) begin
          mb_busy = 1; mb_owner = k; mb_wait = 0;
          break;
        end
      end
    end else if (!(e_mread || e_mwrite)) begin
      mb_busy = 0;
    end else if (!m_waitrequest || e_force) begin
      mb_busy = 0; mb_last = mb_owner;
    end else begin
      mb_wait++;
    end
  endfunction

  task automatic clear_inputs();
    s_address = '0; s_writedata = '0; s_byteenable = '0;
    s_read = '0; s_write = '0;
    m_waitrequest = 1'b0; m_readdata = '0; timeout_clr = 1'b0;
  endtask

  // Leaves the caller at a negedge with the DUT freshly reset and reset released.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL reset_grant: got %b want 000", grant); end
    n_vec++; if (s_waitrequest !== 3'b111) begin n_err++; $display("FAIL reset_swait: got %b want 111", s_waitrequest); end
    n_vec++; if ({m_read, m_write} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {m_read, m_write}); end
    n_vec++; if (timeout !== 1'b0 || timeout_id !== 3'd0) begin n_err++; $display("FAIL reset_timeout: got %b/%0d want 0/0", timeout, timeout_id); end
  endtask

  task automatic test_single_read();
    do_reset();
    s_read[0] = 1'b1; s_address[31:0] = 32'h0000_1040; m_readdata = 32'hA5A5_0001;
    #1;
    n_vec++; if (grant !== 3'b000 || m_read !== 1'b0) begin n_err++; $display("FAIL single_c0: got grant %b m_read %b want 000/0", grant, m_read); end
    @(negedge clk); #1;
    n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL single_grant: got %b want 001", grant); end
    n_vec++; if (m_read !== 1'b1 || m_address !== 32'h0000_1040) begin n_err++; $display("FAIL single_mport: got %b %h want 1 00001040", m_read, m_address); end
    n_vec++; if (s_waitrequest !== 3'b110) begin n_err++; $display("FAIL single_swait: got %b want 110", s_waitrequest); end
    n_vec++; if (s_readdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_rdata: got %h want a5a50001", s_readdata); end
    @(negedge clk); #1;
    n_vec++; if (grant !== 3'b000 || m_read !== 1'b0) begin n_err++; $display("FAIL single_c2: got grant %b m_read %b want 000/0", grant, m_read); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g;
    int           own;
    do_reset();
    for (int k = 0; k < N; k++) s_address[k*32 +: 32] = 32'h100 * (k + 1);
    s_write = '1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_g = '0;
      own   = ((i - 1) / 2) % N;
      if (i % 2 == 1) exp_g[own] = 1'b1;
      n_vec++; if (grant !== exp_g) begin n_err++; $display("FAIL fair_grant step %0d: got %b want %b", i, grant, exp_g); end
      if (i % 2 == 1) begin
        n_vec++;
        if (m_write !== 1'b1 || m_address !== 32'h100 * (own + 1)) begin
          n_err++; $display("FAIL fair_mport step %0d: got %b %h want 1 %h", i, m_write, m_address, 32'h100 * (own + 1));
        end
      end
    end
  endtask

  task automatic test_wait_states();
    logic [N-1:0] exp_sw;
    do_reset();
    s_write[1] = 1'b1; s_address[63:32] = 32'hCAFE_0010; s_writedata[63:32] = 32'h1357_9BDF;
    m_waitrequest = 1'b1;
    #1;
    n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL wait_c0: got %b want 000", grant); end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      s_write[0] = 1'b1; s_write[2] = 1'b1;
      m_waitrequest = (j < 5);
      #1;
      exp_sw = (j < 5) ? 3'b111 : 3'b101;
      n_vec++; if (grant !== 3'b010) begin n_err++; $display("FAIL wait_grant %0d: got %b want 010", j, grant); end
      n_vec++;
      if (m_write !== 1'b1 || m_address !== 32'hCAFE_0010 || m_writedata !== 32'h1357_9BDF) begin
        n_err++; $display("FAIL wait_mport %0d: got %b %h %h want 1 cafe0010 13579bdf", j, m_write, m_address, m_writedata);
      end
      n_vec++; if (s_waitrequest !== exp_sw) begin n_err++; $display("FAIL wait_swait %0d: got %b want %b", j, s_waitrequest, exp_sw); end
    end
    @(negedge clk); #1;
    n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL wait_idle: got %b want 000", grant); end
    @(negedge clk); #1;
    n_vec++; if (grant !== 3'b100) begin n_err++; $display("FAIL wait_next: got %b want 100", grant); end
  endtask

  task automatic test_timeout();
    do_reset();
    s_read[2] = 1'b1; m_waitrequest = 1'b1; m_readdata = 32'h1234_5678;
    #1;
    n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL to_c0: got %b want 000", grant); end
    for (int c = 0; c <= P_TO; c++) begin
      @(negedge clk); #1;
      if (c < P_TO) begin
        n_vec++;
        if (s_waitrequest !== 3'b111 || s_readdata !== 32'h1234_5678 || timeout !== 1'b0) begin
          n_err++; $display("FAIL to_wait %0d: got %b %h %b want 111 12345678 0", c, s_waitrequest, s_readdata, timeout);
        end
      end else begin
        n_vec++; if (s_waitrequest !== 3'b011) begin n_err++; $display("FAIL to_swait: got %b want 011", s_waitrequest); end
        n_vec++; if (s_readdata !== ERR) begin n_err++; $display("FAIL to_rdata: got %h want deadbeef", s_readdata); end
        n_vec++; if (m_read !== 1'b1) begin n_err++; $display("FAIL to_mread_fire: got %b want 1", m_read); end
      end
    end
    @(negedge clk); #1;
    n_vec++; if (m_read !== 1'b0 || grant !== 3'b000) begin n_err++; $display("FAIL to_drop: got m_read %b grant %b want 0/000", m_read, grant); end
    n_vec++; if (timeout !== 1'b1 || timeout_id !== 3'd2) begin n_err++; $display("FAIL to_flag: got %b/%0d want 1/2", timeout, timeout_id); end
    s_read[2] = 1'b0; timeout_clr = 1'b1;
    @(negedge clk);
    timeout_clr = 1'b0;
    #1;
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_clr: got %b want 0", timeout); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_read[0] = 1'b1; m_waitrequest = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (grant !== 3'b001 || m_read !== 1'b1) begin n_err++; $display("FAIL rmid_busy: got %b %b want 001 1", grant, m_read); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; s_read = '1;
    #1;
    n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL rmid_grant: got %b want 000", grant); end
    n_vec++; if ({m_read, m_write} !== 2'b00) begin n_err++; $display("FAIL rmid_strobes: got %b want 00", {m_read, m_write}); end
    n_vec++; if (s_waitrequest !== 3'b111) begin n_err++; $display("FAIL rmid_swait: got %b want 111", s_waitrequest); end
    @(negedge clk); #1;
    n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL rmid_first: got %b want 001", grant); end
  endtask

  task automatic test_withdrawal();
    do_reset();
    s_write[0] = 1'b1; m_waitrequest = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL wd_grant: got %b want 001", grant); end
    @(negedge clk);
    s_write[0] = 1'b0; s_write[1] = 1'b1;
    #1;
    n_vec++; if (grant !== 3'b001 || m_write !== 1'b0) begin n_err++; $display("FAIL wd_drop: got %b %b want 001 0", grant, m_write); end
    @(negedge clk);
    s_write[0] = 1'b1;
    #1;
    n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL wd_idle: got %b want 000", grant); end
    @(negedge clk);
    m_waitrequest = 1'b0;
    #1;
    n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL wd_last: got %b want 001", grant); end
  endtask

  task automatic test_random();
    do_reset();
    model_init();
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 9) < 3) begin
          s_read[k]  = ($urandom_range(0, 2) == 0);
          s_write[k] = ($urandom_range(0, 2) == 0);
        end
      end
      s_address     = {$urandom, $urandom, $urandom};
      s_writedata   = {$urandom, $urandom, $urandom};
      s_byteenable  = 12'($urandom);
      m_waitrequest = ($urandom_range(0, 9) < 6);
      m_readdata    = $urandom;
      timeout_clr   = ($urandom_range(0, 9) == 0);
      #1;
      model_expect();
      n_vec++; if (grant !== e_grant) begin n_err++; $display("FAIL rnd_grant c%0d: got %b want %b", c, grant, e_grant); end
      n_vec++; if (m_read !== e_mread) begin n_err++; $display("FAIL rnd_mread c%0d: got %b want %b", c, m_read, e_mread); end
      n_vec++; if (m_write !== e_mwrite) begin n_err++; $display("FAIL rnd_mwrite c%0d: got %b want %b", c, m_write, e_mwrite); end
      n_vec++; if (m_address !== e_addr) begin n_err++; $display("FAIL rnd_addr c%0d: got %h want %h", c, m_address, e_addr); end
      n_vec++; if (m_writedata !== e_wdata) begin n_err++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, m_writedata, e_wdata); end
      n_vec++; if (m_byteenable !== e_be) begin n_err++; $display("FAIL rnd_be c%0d: got %h want %h", c, m_byteenable, e_be); end
      n_vec++; if (s_waitrequest !== e_swait) begin n_err++; $display("FAIL rnd_swait c%0d: got %b want %b", c, s_waitrequest, e_swait); end
      n_vec++; if (s_readdata !== e_rdata) begin n_err++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, s_readdata, e_rdata); end
      n_vec++; if (timeout !== mb_to) begin n_err++; $display("FAIL rnd_timeout c%0d: got %b want %b", c, timeout, mb_to); end
      n_vec++; if (mb_to && timeout_id !== 3'(mb_toid)) begin n_err++; $display("FAIL rnd_toid c%0d: got %0d want %0d", c, timeout_id, mb_toid); end
      model_advance();
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_fairness();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_withdrawal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_limit: time %0t reached without finishing", $time);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/amm_arbiter.md
Name: amm_arbiter

Overview:
- Shares one downstream Avalon-MM master port between N upstream Avalon-MM requesters, all on one clock.
- Uses round-robin arbitration. The grant is held for the whole transfer until the downstream port drops waitrequest.
- Has an optional watchdog that completes a hung transfer with a fixed error word and a sticky flag.
- Sits between several bus masters (CPU, DMA, and any amm_dsync outputs already retimed into this domain) and one register or peripheral slave.

Parameters:
- N, 2, number of requesters (2..8).
- P_TIMEOUT, 0, maximum wait cycles per transfer. 0 disables the watchdog.
- P_ERR_DATA, 32'hDEAD_BEEF, readdata returned on a timed-out read.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_address  in  N*32  per-requester address; slice k = [32k+31:32k]
- s_writedata  in  N*32  per-requester write data
- s_byteenable  in  N*4  per-requester byte enables
- s_read  in  N  per-requester read strobe
- s_write  in  N  per-requester write strobe
- s_waitrequest  out  N  per-requester waitrequest
- s_readdata  out  32  read data, broadcast to all requesters; meaningful only to the granted one
- m_address  out  32  downstream address
- m_writedata  out  32  downstream write data
- m_byteenable  out  4  downstream byte enables
- m_read  out  1  downstream read strobe
- m_write  out  1  downstream write strobe
- m_waitrequest  in  1  downstream waitrequest
- m_readdata  in  32  downstream read data, valid when m_read & ~m_waitrequest
- grant  out  N  one-hot current owner; 0 when idle
- timeout  out  1  sticky watchdog flag
- timeout_id  out  3  index of the requester that timed out
- timeout_clr  in  1  clears timeout

Behaviour:
- Reset values: grant=0, state=IDLE, last=N-1, timeout=0, timeout_id=0, m_read=m_write=0, s_waitrequest=all ones.
- Request: req[k] = s_read[k] | s_write[k]. Both strobes asserted together is illegal; the arbiter treats it as a read.
- IDLE state:
  - If any req, pick the winner W as the first requesting index after last, scanning cyclically (last+1, last+2, ... mod N).
  - Register grant=onehot(W) and go to BUSY.
  - If no req, stay in IDLE.
  - No m_ strobe is asserted during IDLE.
- BUSY state:
  - m_address, m_writedata, m_byteenable, m_read and m_write are a combinational mux of requester W's inputs, selected by the registered grant.
  - s_waitrequest[W] = m_waitrequest. All other requesters see 1.
  - s_readdata = m_readdata.
  - Completion is m_waitrequest=0 while m_read|m_write is asserted. On completion: last<=W, grant<=0, state<=IDLE on the next edge.
- Latency: a 0-wait slave completes 2 cycles after the request is raised (1 arbitration cycle + 1 transfer cycle). Each completed transfer is followed by one IDLE cycle before the next grant, so peak throughput is 1 transfer per 2 cycles.
- Illegal withdrawal: if the granted requester drops both strobes while in BUSY, the arbiter returns to IDLE on the next edge and last is not updated.
- Non-granted requesters may change or drop their requests freely; only live requests are seen at arbitration.
- Watchdog, when P_TIMEOUT>0:
  - A wait counter is cleared on entry to BUSY and increments every BUSY cycle with m_waitrequest=1.
  - When the counter equals P_TIMEOUT and m_waitrequest is still 1, the arbiter force-completes the transfer:
    - s_waitrequest[W]=0 in that cycle.
    - s_readdata=P_ERR_DATA in that cycle.
    - m_read and m_write are dropped from the next cycle.
    - timeout<=1 and timeout_id<=W.
    - Then IDLE, with last=W.
  - Counter width is $clog2(P_TIMEOUT+1).
- timeout_clr:
  - Clears timeout on the next edge.
  - A new timeout in the same cycle wins: the flag stays set and the id is updated.
- Reset mid-transfer: all outputs return to their reset values on the next edge. Downstream strobes drop immediately, with no handshake completion.

Decomposition:
- Package amm_arb_pkg holds:
  - AMM_AW=32, AMM_DW=32, AMM_BEW=4;
  - typedef enum logic {IDLE, BUSY} arb_state_t;
  - the default error-data constant.
- Sub-module amm_rr_pick: purely combinational. Inputs are req[N] and last index; output is a one-hot winner plus a valid flag. It is reusable by other arbiters.

Test Plan:
- Single requester, 0-wait slave: s_read[0]=1 at cycle 0 → grant=01 at cycle 1, m_read=1, s_waitrequest[0]=0 at cycle 1, s_readdata=m_readdata; IDLE at cycle 2.
- Fairness: N=3, all three write continuously → grant sequence 0,1,2,0,1,2, with one IDLE cycle between grants; no requester is starved.
- Wait states: slave holds m_waitrequest=1 for 5 cycles on a write from requester 1 → m_write and m_address stay stable 6 cycles; s_waitrequest[0] and s_waitrequest[2] stay 1 throughout; grant is unchanged until completion.
- Timeout: P_TIMEOUT=4, slave never deasserts → after 4 wait cycles s_waitrequest[W]=0 and s_readdata=32'hDEAD_BEEF; timeout=1, timeout_id=W; m_read=0 the next cycle. timeout_clr=1 → timeout=0.
- Reset mid-BUSY with m_waitrequest=1 → next cycle grant=0, m_read=m_write=0, s_waitrequest all ones; the next arbitration starts from index 0.
- Withdrawal: the granted requester drops s_write while waiting → return to IDLE; the next pick still starts after the old last.
